uart_rx_core: RTL and testbench

//  8N1 asynchronous serial receiver feeding the CSR block's RX status/data registers.

---
 rtl/uart_rx_core.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_core.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core -- 8N1 asynchronous serial receiver.
//
// Synchronises the rxd pin, finds the start bit, samples every bit at its
// middle and hands complete bytes to a one-deep holding register that the
// CPU drains through CSR reads.
//
// Ports:
//   clk         system clock
//   rst         asynchronous reset, active-high
//   rxd         serial input, idle high, asynchronous to clk
//   rd          single-cycle read strobe; consumes the holding register
//   rdata[7:0]  holding register (stable while d_valid = 1)
//   d_valid     holding register contains an unread byte
//   overflow    sticky: a byte arrived while d_valid = 1 and was dropped
//   clr_ovrflw  level input; clears overflow while high
//   frame_err   one-cycle pulse; stop bit sampled low
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       rd,
  output logic [7:0] rdata,
  output logic       d_valid,
  output logic       overflow,
  input  logic       clr_ovrflw,
  output logic       frame_err
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT >> 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  // ---------------------------------------------------------------------
  // rxd synchroniser; resets to the idle (high) line level so a reset never
  // looks like a start bit.
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync;
  logic                   rxs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rxd};
    end
  end

  assign rxs = sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------
  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      idx, idx_n;
  logic [7:0]      shift, shift_n;
  logic            load;
  logic            ferr_ev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    load    = 1'b0;
    ferr_ev = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          cnt_n   = '0;
          state_n = START;
        end
      end
      START: begin
        // Half a bit after the falling edge we are mid start bit; a high
        // line here means the edge was a glitch.
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (rxs) begin
            state_n = IDLE;
          end else begin
            idx_n   = '0;
            state_n = DATA;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n        = '0;
          shift_n[idx] = rxs;
          idx_n        = idx + 3'd1;
          if (idx == 3'd7) begin
            state_n = STOP;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        // Returning to IDLE at mid stop bit leaves half a bit of margin to
        // catch a back-to-back start edge.
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rxs) begin
            load    = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_ev = 1'b1;
            state_n = BRK;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      BRK: begin
        // Wait out a break condition so a held-low line is not re-read as
        // a stream of start bits.
        if (rxs) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Holding register and status flags
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata     <= 8'h00;
      d_valid   <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= ferr_ev;

      if (load) begin
        // A read in the load cycle frees the slot for the incoming byte.
        if (!d_valid || rd) begin
          rdata <= shift;
        end
        d_valid <= 1'b1;
      end else if (rd) begin
        d_valid <= 1'b0;
      end

      // Set has priority over clear so a simultaneous event is not lost.
      if (load && d_valid && !rd) begin
        overflow <= 1'b1;
      end else if (clr_ovrflw) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core -- directed self-checking bench for uart_rx_core
// (CLKS_PER_BIT = 16, SYNC_STAGES = 2, rxd driven at the exact bit rate).
module tb_uart_rx_core;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       rd = 1'b0;
  logic       clr_ovrflw = 1'b0;
  logic [7:0] rdata;
  logic       d_valid;
  logic       overflow;
  logic       frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc         = 0;
  int dv_rise_cyc = -1;
  int ferr_count  = 0;
  int fall_cyc    = 0;
  logic dv_prev   = 1'b0;

  uart_rx_core #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rd        (rd),
    .rdata     (rdata),
    .d_valid   (d_valid),
    .overflow  (overflow),
    .clr_ovrflw(clr_ovrflw),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: d_valid rise time and frame_err high cycles.
  always @(negedge clk) begin
    if (d_valid && !dv_prev) dv_rise_cyc <= cyc;
    dv_prev <= d_valid;
    if (frame_err) ferr_count <= ferr_count + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start bit, 8 data bits LSB first, stop bit; the line is left at the
  // stop-bit level so a low stop bit can be stretched into a break.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    fall_cyc = cyc;
    rxd = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) tick();
    end
    rxd = stop;
    repeat (CPB) tick();
    $display("frame 0x%02h stop=%0b sent: rdata=0x%02h d_valid=%0b overflow=%0b",
             b, stop, rdata, d_valid, overflow);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({rdata, d_valid, overflow, frame_err} !== 11'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdata=%h dv=%b ov=%b fe=%b, expected all 0",
               rdata, d_valid, overflow, frame_err);
    end
    rst = 1'b0;
    repeat (20) tick();
    n_checks++;
    if (d_valid !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got dv=%b fe=%b, expected 0 0", d_valid, frame_err);
    end
  endtask

  task automatic test_single_frame();
    int base_ferr;
    int lat;
    base_ferr = ferr_count;
    send_frame(8'hA5, 1'b1);
    repeat (2) tick();
    lat = dv_rise_cyc - fall_cyc;
    n_checks++;
    if (dv_rise_cyc <= fall_cyc || lat < 152 || lat > 156) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles, expected 152..156", lat);
    end
    n_checks++;
    if (rdata !== 8'hA5 || d_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_a5: got rdata=%h dv=%b, expected a5 1", rdata, d_valid);
    end
    n_checks++;
    if (overflow !== 1'b0 || ferr_count !== base_ferr) begin
      n_fail++;
      $display("FAIL frame_a5_flags: got ov=%b ferr_cycles=%0d, expected 0 %0d",
               overflow, ferr_count, base_ferr);
    end
  endtask

  task automatic test_read();
    rd = 1'b1;
    tick();
    rd = 1'b0;
    n_checks++;
    if (d_valid !== 1'b0 || rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL read_consume: got dv=%b rdata=%h, expected 0 a5", d_valid, rdata);
    end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    tick();
    n_checks++;
    if (d_valid !== 1'b0 || rdata !== 8'hA5 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL read_empty: got dv=%b rdata=%h ov=%b, expected 0 a5 0",
               d_valid, rdata, overflow);
    end
  endtask

  task automatic test_overflow();
    send_frame(8'h3C, 1'b1);
    n_checks++;
    if (rdata !== 8'h3C || d_valid !== 1'b1 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL first_3c: got rdata=%h dv=%b ov=%b, expected 3c 1 0",
               rdata, d_valid, overflow);
    end
    send_frame(8'hC3, 1'b1);
    n_checks++;
    if (rdata !== 8'h3C || d_valid !== 1'b1 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_set: got rdata=%h dv=%b ov=%b, expected 3c 1 1",
               rdata, d_valid, overflow);
    end
    clr_ovrflw = 1'b1;
    tick();
    clr_ovrflw = 1'b0;
    tick();
    n_checks++;
    if (overflow !== 1'b0 || d_valid !== 1'b1 || rdata !== 8'h3C) begin
      n_fail++;
      $display("FAIL overflow_clear: got ov=%b dv=%b rdata=%h, expected 0 1 3c",
               overflow, d_valid, rdata);
    end
  endtask

  task automatic test_back_to_back();
    // Drain, then hold 0x11.
    rd = 1'b1;
    tick();
    rd = 1'b0;
    send_frame(8'h11, 1'b1);
    n_checks++;
    if (rdata !== 8'h11 || d_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_11: got rdata=%h dv=%b, expected 11 1", rdata, d_valid);
    end
    // Load happens on the 155th clock edge after the rxd fall, so rd is
    // raised after 154 ticks to be sampled on that edge.
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (154) tick();
        rd = 1'b1;
        tick();
        rd = 1'b0;
      end
    join
    n_checks++;
    if (rdata !== 8'h77 || d_valid !== 1'b1 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_in_load: got rdata=%h dv=%b ov=%b, expected 77 1 0",
               rdata, d_valid, overflow);
    end
  endtask

  task automatic test_glitch_break();
    int base_ferr;
    rd = 1'b1;
    tick();
    rd = 1'b0;
    base_ferr = ferr_count;
    rxd = 1'b0;
    repeat (4) tick();
    rxd = 1'b1;
    repeat (40) tick();
    $display("glitch sent: d_valid=%0b frame_err_cycles=%0d", d_valid, ferr_count - base_ferr);
    n_checks++;
    if (d_valid !== 1'b0 || ferr_count !== base_ferr) begin
      n_fail++;
      $display("FAIL glitch: got dv=%b ferr_cycles=%0d, expected 0 %0d",
               d_valid, ferr_count, base_ferr);
    end
    send_frame(8'h55, 1'b0);
    repeat (40) tick();
    n_checks++;
    if (ferr_count !== base_ferr + 1) begin
      n_fail++;
      $display("FAIL frame_err_pulse: got %0d cycles, expected %0d",
               ferr_count - base_ferr, 1);
    end
    n_checks++;
    if (d_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_err_discard: got dv=%b, expected 0", d_valid);
    end
    rxd = 1'b1;
    repeat (16) tick();
    send_frame(8'h12, 1'b1);
    n_checks++;
    if (rdata !== 8'h12 || d_valid !== 1'b1 || ferr_count !== base_ferr + 1) begin
      n_fail++;
      $display("FAIL after_break: got rdata=%h dv=%b ferr_cycles=%0d, expected 12 1 %0d",
               rdata, d_valid, ferr_count - base_ferr, 1);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    send_frame(8'h99, 1'b1);
    n_checks++;
    if (overflow !== 1'b1 || rdata !== 8'h12) begin
      n_fail++;
      $display("FAIL pre_reset_state: got ov=%b rdata=%h, expected 1 12", overflow, rdata);
    end
    b = 8'hC9;
    rxd = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      repeat (CPB) tick();
    end
    rxd = b[4];
    repeat (CPB / 2) tick();
    rst = 1'b1;
    #2;
    $display("reset asserted mid-frame: rdata=0x%02h d_valid=%0b overflow=%0b",
             rdata, d_valid, overflow);
    n_checks++;
    if ({rdata, d_valid, overflow, frame_err} !== 11'h000) begin
      n_fail++;
      $display("FAIL async_reset: got rdata=%h dv=%b ov=%b fe=%b, expected all 0",
               rdata, d_valid, overflow, frame_err);
    end
    rxd = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (32) tick();
    n_checks++;
    if (d_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL aborted_frame: got dv=%b, expected 0", d_valid);
    end
    send_frame(8'hF0, 1'b1);
    n_checks++;
    if (rdata !== 8'hF0 || d_valid !== 1'b1 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_f0: got rdata=%h dv=%b ov=%b, expected f0 1 0",
               rdata, d_valid, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_read();
    test_overflow();
    test_back_to_back();
    test_glitch_break();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
